// File: rtl/phreg_free_list.sv
// Circular FIFO of free physical register tags feeding rename.
// Grants up to NUM_PORTS tags per cycle (all-or-nothing) and accepts commit releases.
module phreg_free_list #(
    parameter int unsigned NUM_PORTS     = 2,
    parameter int unsigned NUM_PHYS_REGS = 64,
    parameter int unsigned NUM_ARCH_REGS = 32,
    parameter int unsigned DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS,
    parameter int unsigned TAG_W         = $clog2(NUM_PHYS_REGS),
    parameter int unsigned CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_PORTS-1:0]       alloc_req_i,
    output logic [NUM_PORTS-1:0]       alloc_valid_o,
    output logic [NUM_PORTS*TAG_W-1:0] alloc_tag_o,
    output logic                       alloc_stall_o,
    input  logic [NUM_PORTS-1:0]       release_valid_i,
    input  logic [NUM_PORTS*TAG_W-1:0] release_tag_i,
    output logic [CNT_W-1:0]           free_count_o,
    output logic                       empty_o,
    output logic                       overflow_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TAG_W-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [NUM_PORTS-1:0] wr_en;
    logic [PTR_W-1:0]     wr_ptr [NUM_PORTS];

    int unsigned cnt, n_req, n_grant, n_acc, space, off;
    logic        grant, drop;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input int unsigned off_in);
        int unsigned s;
        s = 32'(p) + off_in;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    always_comb begin
        cnt           = 32'(count_q);
        n_req         = 0;
        off           = 0;
        n_acc         = 0;
        drop          = 1'b0;
        alloc_tag_o   = '0;
        alloc_valid_o = '0;
        wr_en         = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            wr_ptr[k] = '0;
            if (alloc_req_i[k]) n_req = n_req + 1;
        end

        grant         = (cnt >= n_req);
        alloc_stall_o = (n_req != 0) && !grant && !rst_i;
        n_grant       = grant ? n_req : 0;
        if (grant && !rst_i) alloc_valid_o = alloc_req_i;

        // Lane k reads head + (number of requesting lanes below k).
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (alloc_req_i[k]) begin
                if (grant) alloc_tag_o[k*TAG_W +: TAG_W] = entry_q[ptr_add(head_q, off)];
                off = off + 1;
            end
        end

        // Space counts slots vacated by this cycle's grant; tag 0 is never returned.
        space = DEPTH - (cnt - n_grant);
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (release_valid_i[k] && (release_tag_i[k*TAG_W +: TAG_W] != '0)) begin
                if (n_acc < space) begin
                    wr_en[k]  = 1'b1;
                    wr_ptr[k] = ptr_add(tail_q, n_acc);
                    n_acc     = n_acc + 1;
                end else begin
                    drop = 1'b1;
                end
            end
        end

        head_d     = ptr_add(head_q, n_grant);
        tail_d     = ptr_add(tail_q, n_acc);
        count_d    = CNT_W'(cnt - n_grant + n_acc);
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= TAG_W'(NUM_ARCH_REGS + i);
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= CNT_W'(DEPTH);
            overflow_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (wr_en[k]) entry_q[wr_ptr[k]] <= release_tag_i[k*TAG_W +: TAG_W];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign free_count_o = count_q;
    assign empty_o      = (count_q == '0);
    assign overflow_o   = overflow_q;

endmodule
